sine_table_player: RTL
======================

Name: sine_table_player

Overview:
- Downstream consumer of the half-sine lookup table (72 entries, 12-bit, rising 0→4093).
- Walks the table up, then mirrored back down, to synthesise a full-period raised-sine waveform.
- Paces samples with a programmable clock divider and hands each 12-bit sample to the DAC/output stage over a valid/ready handshake.
- Supports one-shot N-cycle bursts and continuous playback.

Parameters:
- DATA_W, 12, sample width; matches the table entry width.
- TABLE_DEPTH, 72, number of table entries.
- DIV_W, 16, width of the clocks-per-sample divider.
- CYC_W, 8, width of the burst cycle count.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sine_wave  input  DATA_W x TABLE_DEPTH  table contents; unpacked array [0:TABLE_DEPTH-1]
- table_size  input  7  number of valid entries
- start  input  1  single-cycle request to begin playback
- stop  input  1  single-cycle request to abort playback
- clk_div  input  DIV_W  clocks per sample; 0 is treated as 1
- num_cycles  input  CYC_W  waveform periods to play; 0 = continuous
- sample_out  output  DATA_W  current sample
- sample_valid  output  1  sample_out holds a sample that has not yet been accepted
- sample_ready  input  1  downstream accepts the sample when high together with sample_valid
- busy  output  1  high in RISE, FALL and DRAIN
- cycle_done  output  1  one-cycle pulse at the end of each waveform period
- done  output  1  one-cycle pulse when playback ends

Behaviour:
- Reset values:
  - sample_out=0, sample_valid=0, busy=0, cycle_done=0, done=0.
  - State IDLE; index, divider and cycle counter all 0.
- States: IDLE, RISE, FALL, DRAIN.
- IDLE + start:
  - Latch div_l = max(clk_div, 1) and cyc_l = num_cycles.
  - Latch size_l = table_size; if table_size < 2 or table_size > TABLE_DEPTH, use TABLE_DEPTH.
  - Clear the divider and cycle counter, set index=0, enter RISE.
  - If start and stop arrive together in IDLE, stop wins and the block stays in IDLE.
  - start is ignored while busy.
- Sample tick:
  - The divider counts 0..div_l-1 in RISE and FALL.
  - A tick fires when the divider reaches div_l-1 and the output slot is free (!sample_valid || sample_ready).
  - If the slot is not free, the divider holds at its terminal value. Samples are stalled, never dropped.
  - The first sample_valid rises on the div_l-th rising edge after the edge that samples start.
  - With back-to-back acceptance, samples are spaced exactly div_l cycles apart.
- On each tick:
  - sample_out <= sine_wave[index], sample_valid <= 1, divider <= 0.
- Handshake:
  - sample_out is stable while sample_valid=1 and sample_ready=0.
  - A transfer completes in any cycle with sample_valid && sample_ready.
  - sample_valid falls the next cycle unless a tick loads a new sample in the same cycle.
- Index sequencing (period = 2*size_l-2 samples; the peak and zero entries are not duplicated):
  - RISE emits index 0..size_l-1; after emitting size_l-1, move to FALL with index=size_l-2.
  - FALL emits size_l-2 down to 1.
  - After emitting index 1: pulse cycle_done and increment the cycle counter.
  - If cyc_l != 0 and the counter equals cyc_l, go to DRAIN; otherwise return to RISE with index=0.
- DRAIN:
  - No new ticks.
  - Wait until sample_valid=0, or until the last sample is accepted in that cycle.
  - Then pulse done, clear busy, return to IDLE.
- stop in RISE or FALL:
  - Go to DRAIN immediately; a tick in the same cycle is suppressed.
  - The pending sample still completes its handshake.
  - done pulses, cycle_done does not.
- rst at any time: return to reset values; any pending sample is discarded.
- Table is read combinationally; contents must be stable while busy.

Decomposition:
- Package sine_pkg holds:
  - DATA_W, TABLE_DEPTH, DIV_W, CYC_W.
  - The state enum {IDLE, RISE, FALL, DRAIN}.
  - Derived period constant PERIOD = 2*TABLE_DEPTH-2.
- One sub-module, sample_rate_divider:
  - Counter with load, hold (stall) and terminal-tick output.
  - Reused by later waveform stages.

Test Plan:
- clk_div=1, num_cycles=1, table_size=72, sample_ready=1 → 142 samples: #0=0, #1=2, #71=4093, #72=4087, #141=2. cycle_done and done pulse; busy falls after the last transfer.
- clk_div=4, num_cycles=1 → first sample_valid 4 edges after start; samples spaced 4 cycles apart; 142 samples total.
- Backpressure: sample_ready held low 10 cycles while sample #5 (=49) is presented → sample_out stays 49, no sample lost; #6=70 follows once ready returns.
- num_cycles=0 → cycle_done every 142 samples; sample #142=0. stop after the third cycle_done → no further samples, pending sample accepted, done pulses once.
- table_size=0 → period 142 samples (clamped); table_size=10 → period 18, peak sample #9=sine_wave[9]=156.
- rst asserted mid-FALL with a pending sample → next cycle sample_valid=0, busy=0, sample_out=0. A new start replays from sample 0.

Source files
------------

// File: rtl/sine_pkg.sv
// Shared constants and state encoding for the sine table playback path.
// Widths here must match the half-sine lookup table that feeds the player.
package sine_pkg;

   localparam int DATA_W      = 12;
   localparam int TABLE_DEPTH = 72;
   localparam int DIV_W       = 16;
   localparam int CYC_W       = 8;
   localparam int IDX_W       = 7;
   localparam int PERIOD      = 2 * TABLE_DEPTH - 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RISE  = 2'd1,
      FALL  = 2'd2,
      DRAIN = 2'd3
   } play_state_t;

endpackage

// File: rtl/sample_rate_divider.sv
// Clocks-per-sample counter: counts 0..div-1, ticks at the terminal count and
// parks there while the consumer is stalled so no sample slot is lost.
module sample_rate_divider
   import sine_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic             hold,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] count;
   logic             at_term;

   // div is never 0 here; the caller clamps it to at least 1.
   assign at_term = (count == div - DIV_W'(1));
   assign tick    = enable && !hold && at_term;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         if (at_term) begin
            if (!hold) count <= '0;
         end else begin
            count <= count + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/sine_table_player.sv
// Plays a half-sine table up then mirrored down as a full raised-sine period,
// paced by a divider and delivered over valid/ready.
module sine_table_player
   import sine_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] sine_wave [0:TABLE_DEPTH-1],
   input  logic [IDX_W-1:0]  table_size,
   input  logic              start,
   input  logic              stop,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic [CYC_W-1:0]  num_cycles,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              busy,
   output logic              cycle_done,
   output logic              done,
   output play_state_t       dbg_state
);

   // Handshake: a sample transfers in any cycle where sample_valid && sample_ready;
   // sample_out is held stable while sample_valid is high and sample_ready is low.

   localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(TABLE_DEPTH);

   play_state_t       state, state_n;
   logic [IDX_W-1:0]  index, index_n;
   logic [IDX_W-1:0]  size_l, size_n;
   logic [DIV_W-1:0]  div_l, div_n;
   logic [CYC_W-1:0]  cyc_l, cyc_l_n;
   logic [CYC_W-1:0]  cyc_cnt, cyc_cnt_n;
   logic [DATA_W-1:0] out_n;
   logic              valid_n;
   logic              cycle_done_n, done_n;
   logic              div_clear, div_enable, div_hold, tick, end_period;

   assign busy       = (state != IDLE);
   assign dbg_state  = state;
   assign div_enable = ((state == RISE) || (state == FALL)) && !stop;
   assign div_hold   = sample_valid && !sample_ready;

   sample_rate_divider u_div (
      .clk    (clk),
      .rst    (rst),
      .clear  (div_clear),
      .enable (div_enable),
      .hold   (div_hold),
      .div    (div_l),
      .tick   (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         index        <= '0;
         size_l       <= '0;
         div_l        <= '0;
         cyc_l        <= '0;
         cyc_cnt      <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         cycle_done   <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_n;
         index        <= index_n;
         size_l       <= size_n;
         div_l        <= div_n;
         cyc_l        <= cyc_l_n;
         cyc_cnt      <= cyc_cnt_n;
         sample_out   <= out_n;
         sample_valid <= valid_n;
         cycle_done   <= cycle_done_n;
         done         <= done_n;
      end
   end

   always_comb begin
      state_n      = state;
      index_n      = index;
      size_n       = size_l;
      div_n        = div_l;
      cyc_l_n      = cyc_l;
      cyc_cnt_n    = cyc_cnt;
      out_n        = sample_out;
      valid_n      = sample_valid && !sample_ready;
      cycle_done_n = 1'b0;
      done_n       = 1'b0;
      div_clear    = 1'b0;
      end_period   = 1'b0;

      if (tick) begin
         out_n   = sine_wave[index];
         valid_n = 1'b1;
      end

      case (state)
         IDLE: begin
            if (start && !stop) begin
               div_n     = (clk_div == '0) ? DIV_W'(1) : clk_div;
               cyc_l_n   = num_cycles;
               size_n    = (table_size < IDX_W'(2) || table_size > DEPTH_IDX) ? DEPTH_IDX : table_size;
               cyc_cnt_n = '0;
               index_n   = '0;
               div_clear = 1'b1;
               state_n   = RISE;
            end
         end
         RISE: begin
            if (stop) begin
               state_n = DRAIN;
            end else if (tick) begin
               if (index == size_l - IDX_W'(1)) begin
                  // A two-entry table has no falling half; its peak ends the period.
                  if (size_l == IDX_W'(2)) begin
                     end_period = 1'b1;
                  end else begin
                     index_n = size_l - IDX_W'(2);
                     state_n = FALL;
                  end
               end else begin
                  index_n = index + IDX_W'(1);
               end
            end
         end
         FALL: begin
            if (stop) begin
               state_n = DRAIN;
            end else if (tick) begin
               if (index == IDX_W'(1)) end_period = 1'b1;
               else                    index_n = index - IDX_W'(1);
            end
         end
         DRAIN: begin
            if (!sample_valid || sample_ready) begin
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (end_period) begin
         cycle_done_n = 1'b1;
         cyc_cnt_n    = cyc_cnt + CYC_W'(1);
         if (cyc_l != '0 && cyc_cnt_n == cyc_l) begin
            state_n = DRAIN;
         end else begin
            state_n = RISE;
            index_n = '0;
         end
      end
   end

endmodule
